instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries (power of two, at least 2).
REQ-002 Parameter RESET_PC, default 32'h0, byte address fetched first after reset.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 imem_req  out  1  instruction-RAM read strobe.
REQ-006 imem_addr  out  32  word address (byte PC / 4).
REQ-007 imem_rdata  in  32  read data, valid exactly 1 cycle after imem_req.
REQ-008 redirect  in  1  branch/jump taken; flush and refetch.
REQ-009 redirect_pc  in  32  byte target address.
REQ-010 deq  in  1  decode stage consumes head entry (decode not stalled).
REQ-011 out_valid  out  1  head entry present.
REQ-012 out_instr  out  32  head instruction.
REQ-013 out_pc_plus4  out  32  head entry's PC + 4.
REQ-014 halt_seen  out  1  halt word 32'hFFFFFFFF fetched; fetching stopped.

Function
REQ-015 Queue SHALL store {instr, pc_plus4} pairs in FIFO order; out_* SHALL show the head combinationally from storage.
REQ-016 imem_req SHALL assert only when occupancy + in-flight < DEPTH, halt_seen = 0, and no redirect this cycle.
REQ-017 At most one request SHALL be in flight; a response SHALL be enqueued on the edge ending the cycle after its request.
REQ-018 fetch_pc SHALL advance by 4 on every issued request, wrapping 32'hFFFFFFFC -> 32'h0.
REQ-019 deq with out_valid = 0 SHALL be ignored; deq and enqueue in the same cycle SHALL leave occupancy unchanged.
REQ-020 Redirect SHALL empty the queue, kill any in-flight response, clear halt_seen, and set fetch_pc to redirect_pc with bits [1:0] forced to 0.
REQ-021 First request after a redirect SHALL issue in the following cycle; that entry's out_valid SHALL rise two cycles after the redirect edge.
REQ-022 Redirect and deq in the same cycle: redirect SHALL win; the queue is empty afterwards.
REQ-023 A response equal to 32'hFFFFFFFF SHALL be enqueued normally and set halt_seen; no further requests issue until redirect or reset.
REQ-024 From reset release, the first request SHALL issue in cycle 1 and out_valid SHALL rise in cycle 3.
REQ-025 Read and write pointers SHALL be log2(DEPTH) bits with a separate occupancy count of width log2(DEPTH)+1; full and empty are derived from the count.

Reset
REQ-026 Asserting rst_n low SHALL immediately force out_valid = 0, imem_req = 0, halt_seen = 0, pointers and count = 0, in-flight = 0, and fetch_pc = RESET_PC.
REQ-027 A response that arrives after reset asserts mid-operation SHALL be discarded.

Structure
REQ-028 Shared package SHALL hold HALT_INSTR (32'hFFFFFFFF), the default DEPTH, and the fetch-entry struct type {instr[31:0], pc_plus4[31:0]}.
REQ-029 Queue storage SHALL be a sub-module fetch_fifo (push, pop, flush, full, empty, count); the fetch controller wraps it.

Verification
REQ-030 Reset release with RAM word n = n -> out_instr 0, 1, 2 from cycle 3, with out_pc_plus4 = 4, 8, 12.
REQ-031 deq held 0 for 10 cycles -> exactly DEPTH = 4 entries; imem_req deasserts, and no entry is lost or duplicated after deq resumes.
REQ-032 redirect with redirect_pc = 32'h43 while a request is in flight -> stale word dropped, queue empty, next imem_addr = 32'h10, and out_valid returns 2 cycles later.
REQ-033 Word 3 = 32'hFFFFFFFF -> halt_seen = 1 after enqueue, no requests beyond address 3, then a redirect to 0 resumes fetching.
REQ-034 redirect and deq in the same cycle with 3 entries queued -> queue empty next cycle; only the target stream appears.
REQ-035 rst_n pulsed low mid-stream -> outputs clear asynchronously, and fetching restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package instr_fetch_queue_pkg;

  // Default number of queue entries (power of two, at least 2).
  localparam int DEFAULT_DEPTH = 4;

  // Fetching this word stops the fetch engine until redirect or reset.
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  // One queued fetch result: the instruction and the address after it.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  // Byte PC to instruction-RAM word address.
  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return {2'b00, pc[31:2]};
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bundle of the instruction-RAM port, redirect input and decode-side outputs.
// master = the fetch queue, slave = the surrounding pipeline / RAM.
interface instr_fetch_queue_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;
  logic        halt_seen;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc_plus4, halt_seen,
    input  imem_rdata, redirect, redirect_pc, deq
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc_plus4, halt_seen,
    output imem_rdata, redirect, redirect_pc, deq
  );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// Circular FIFO of fetch entries with a separate occupancy count.
// Head entry is read combinationally from storage.
module fetch_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  fetch_entry_t     i_entry,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count,
  output fetch_entry_t     o_head
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  // Flush dominates; pushes into a full queue and pops from an empty one are ignored.
  assign w_push_ok = i_push && !o_full  && !i_flush;
  assign w_pop_ok  = i_pop  && !o_empty && !i_flush;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage write port.
  // NOTE: storage has no reset -- validity is tracked by the count, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_entry;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues one-cycle-latency reads to instruction RAM,
// buffers {instr, pc_plus4} results for decode, handles redirect and halt.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic                  clk,
  input logic                  rst_n,
  instr_fetch_queue_if.master  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      r_fetch_pc;
  logic             r_inflight;
  logic             r_halt;
  logic             r_started;

  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_resp_entry;
  logic [CNT_W:0]   w_occupancy;
  logic             w_resp_valid;
  logic             w_resp_halt;
  logic             w_room;
  logic             w_issue;
  logic             w_pop;

  // A response is live only in the cycle after its request; a redirect in that cycle kills it.
  assign w_resp_valid = r_inflight && !bus.redirect;
  assign w_resp_halt  = w_resp_valid && (bus.imem_rdata == HALT_INSTR);

  // The in-flight word already owns a slot, so it counts against capacity.
  assign w_occupancy  = {1'b0, w_count} + (CNT_W + 1)'(r_inflight);
  assign w_room       = (w_occupancy < (CNT_W + 1)'(DEPTH));

  // r_started holds off the first request for one cycle after reset release.
  // A halt word arriving this cycle already blocks the next request.
  assign w_issue      = r_started && w_room && !r_halt && !w_resp_halt && !bus.redirect;

  // Redirect wins over a same-cycle dequeue.
  assign w_pop        = bus.deq && !w_empty && !bus.redirect;

  // fetch_pc advanced at the request edge, so during the response cycle it already equals PC + 4.
  assign w_resp_entry = '{instr: bus.imem_rdata, pc_plus4: r_fetch_pc};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_resp_valid && !w_full),
    .i_entry (w_resp_entry),
    .i_pop   (w_pop),
    .i_flush (bus.redirect),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Fetch PC, in-flight tracking and halt state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_halt     <= 1'b0;
      r_started  <= 1'b0;
    end else begin
      r_started  <= 1'b1;
      r_inflight <= w_issue;
      if (bus.redirect) begin
        r_fetch_pc <= align_pc(bus.redirect_pc);
        r_halt     <= 1'b0;
      end else begin
        if (w_issue)     r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_resp_halt) r_halt     <= 1'b1;
      end
    end
  end

  assign bus.imem_req     = w_issue;
  assign bus.imem_addr    = word_addr(r_fetch_pc);
  assign bus.out_valid    = !w_empty;
  assign bus.out_instr    = w_head.instr;
  assign bus.out_pc_plus4 = w_head.pc_plus4;
  assign bus.halt_seen    = r_halt;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: a RAM model answers requests, the
// expected {instr, pc_plus4} stream is predicted from the bench's own PC model.
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst_n;

  instr_fetch_queue_if bus ();

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  fetch_entry_t sb[$];
  logic         inf_valid;
  fetch_entry_t inf_entry;
  logic [31:0]  m_pc;
  logic         m_halt;
  logic         prev_req;
  logic [31:0]  prev_addr;
  logic         halt_en;
  logic [31:0]  halt_waddr;
  int           n_req;

  // Values sampled in the most recent cycle
  logic         s_req, s_valid, s_halt;
  logic [31:0]  s_addr, s_instr, s_pc4;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] waddr);
    return (halt_en && waddr == halt_waddr) ? HALT_INSTR : waddr;
  endfunction

  // One clock cycle: drive inputs just after the edge, sample at negedge, update model.
  task automatic run_cycle(input logic i_deq, input logic i_redir, input logic [31:0] i_rpc);
    bus.deq         = i_deq;
    bus.redirect    = i_redir;
    bus.redirect_pc = i_rpc;
    bus.imem_rdata  = prev_req ? mem_word(prev_addr) : 32'hDEAD_BEEF;
    @(negedge clk);
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = bus.out_valid;
    s_instr = bus.out_instr;
    s_pc4   = bus.out_pc_plus4;
    s_halt  = bus.halt_seen;

    check("out_valid", s_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      check("head_instr", s_instr, sb[0].instr);
      check("head_pc_plus4", s_pc4, sb[0].pc_plus4);
    end
    check("halt_seen", s_halt, m_halt);
    if (m_halt || i_redir) check("req_blocked", s_req, 1'b0);
    if (s_req) begin
      check("imem_addr", s_addr, m_pc >> 2);
      n_req++;
    end

    if (i_redir) begin
      sb.delete();
      inf_valid = 1'b0;
      m_pc      = {i_rpc[31:2], 2'b00};
      m_halt    = 1'b0;
    end else begin
      if (i_deq && sb.size() != 0) void'(sb.pop_front());
      if (inf_valid) begin
        sb.push_back(inf_entry);
        if (inf_entry.instr == HALT_INSTR) m_halt = 1'b1;
      end
      inf_valid = s_req;
      if (s_req) begin
        inf_entry = '{instr: mem_word(m_pc >> 2), pc_plus4: m_pc + 32'd4};
        m_pc      = m_pc + 32'd4;
      end
    end
    check("occupancy_bound", (sb.size() + int'(inf_valid)) <= DEPTH, 1'b1);
    prev_req  = s_req;
    prev_addr = s_addr;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse; returns at the start of cycle 1 after release.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_imem_req", bus.imem_req, 1'b0);
    check("rst_halt_seen", bus.halt_seen, 1'b0);
    bus.deq         = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    sb.delete();
    inf_valid = 1'b0;
    m_pc      = RESET_PC;
    m_halt    = 1'b0;
    prev_req  = 1'b0;
    prev_addr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("cycle0_no_req", bus.imem_req, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.deq         = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    halt_en         = 1'b0;
    halt_waddr      = 32'd3;
    n_req           = 0;
    do_reset();

    // Startup stream: request in cycle 1, data 0,1,2 from cycle 3
    run_cycle(1'b1, 1'b0, 32'h0);
    check("c1_req", s_req, 1'b1);
    check("c1_addr", s_addr, 32'h0);
    run_cycle(1'b1, 1'b0, 32'h0);
    check("c2_valid", s_valid, 1'b0);
    run_cycle(1'b1, 1'b0, 32'h0);
    check("c3_valid", s_valid, 1'b1);
    check("c3_instr", s_instr, 32'd0);
    check("c3_pc4", s_pc4, 32'd4);
    run_cycle(1'b1, 1'b0, 32'h0);
    check("c4_instr", s_instr, 32'd1);
    check("c4_pc4", s_pc4, 32'd8);
    run_cycle(1'b1, 1'b0, 32'h0);
    check("c5_instr", s_instr, 32'd2);
    check("c5_pc4", s_pc4, 32'd12);

    // Decode stalled: queue fills to DEPTH and fetching stops
    repeat (10) run_cycle(1'b0, 1'b0, 32'h0);
    check("full_req_off", s_req, 1'b0);
    check("full_valid", s_valid, 1'b1);
    check("full_entries", sb.size(), DEPTH);
    repeat (12) run_cycle(1'b1, 1'b0, 32'h0);

    // Redirect to 0x43 with a word in flight
    check("stream_req", s_req, 1'b1);
    run_cycle(1'b1, 1'b1, 32'h43);
    run_cycle(1'b1, 1'b0, 32'h0);
    check("redir_req", s_req, 1'b1);
    check("redir_addr", s_addr, 32'h10);
    check("redir_valid1", s_valid, 1'b0);
    run_cycle(1'b1, 1'b0, 32'h0);
    check("redir_valid2", s_valid, 1'b0);
    run_cycle(1'b1, 1'b0, 32'h0);
    check("redir_valid3", s_valid, 1'b1);
    check("redir_instr", s_instr, 32'h10);
    check("redir_pc4", s_pc4, 32'h44);
    repeat (6) run_cycle(1'b1, 1'b0, 32'h0);

    // Halt word at address 3
    halt_en = 1'b1;
    run_cycle(1'b0, 1'b1, 32'h0);
    n_req = 0;
    repeat (12) run_cycle(1'b1, 1'b0, 32'h0);
    check("halt_req_count", n_req, 4);
    check("halt_set", s_halt, 1'b1);
    run_cycle(1'b1, 1'b1, 32'h0);
    run_cycle(1'b1, 1'b0, 32'h0);
    check("resume_req", s_req, 1'b1);
    check("resume_addr", s_addr, 32'h0);
    check("halt_cleared", s_halt, 1'b0);
    halt_en = 1'b0;
    repeat (6) run_cycle(1'b1, 1'b0, 32'h0);

    // Redirect and deq together with three entries queued
    run_cycle(1'b0, 1'b1, 32'h300);
    repeat (4) run_cycle(1'b0, 1'b0, 32'h0);
    check("three_queued", sb.size(), 3);
    run_cycle(1'b1, 1'b1, 32'h200);
    run_cycle(1'b1, 1'b0, 32'h0);
    check("rd_empty", s_valid, 1'b0);
    check("rd_addr", s_addr, 32'h80);
    run_cycle(1'b1, 1'b0, 32'h0);
    run_cycle(1'b1, 1'b0, 32'h0);
    check("rd_instr", s_instr, 32'h80);
    repeat (5) run_cycle(1'b1, 1'b0, 32'h0);

    // fetch_pc wraps from 0xFFFFFFFC to 0
    run_cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (3) run_cycle(1'b1, 1'b0, 32'h0);
    check("wrap_pc4_a", s_pc4, 32'hFFFF_FFFC);
    run_cycle(1'b1, 1'b0, 32'h0);
    check("wrap_pc4_b", s_pc4, 32'h0);
    run_cycle(1'b1, 1'b0, 32'h0);
    check("wrap_instr_c", s_instr, 32'h0);
    check("wrap_pc4_c", s_pc4, 32'h4);
    repeat (3) run_cycle(1'b1, 1'b0, 32'h0);

    // Reset mid-stream while a response is arriving
    check("pre_reset_valid", s_valid, 1'b1);
    bus.imem_rdata = prev_req ? mem_word(prev_addr) : 32'hDEAD_BEEF;
    #2;
    do_reset();
    run_cycle(1'b1, 1'b0, 32'h0);
    check("rst_c1_req", s_req, 1'b1);
    check("rst_c1_addr", s_addr, RESET_PC >> 2);
    run_cycle(1'b1, 1'b0, 32'h0);
    check("rst_c2_valid", s_valid, 1'b0);
    run_cycle(1'b1, 1'b0, 32'h0);
    check("rst_c3_instr", s_instr, 32'd0);
    check("rst_c3_pc4", s_pc4, 32'd4);
    repeat (4) run_cycle(1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
